// File: rtl/m_cache_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module  : m_cache_fill_pkg
// Brief   : Shared types and constants for the cache miss/refill controller.
// Revision: 1.0 - initial release
// ============================================================================
package m_cache_fill_pkg;

    localparam int c_EADDR_WIDTH = 32;
    localparam int c_LINE_WORDS  = 4;
    localparam int c_WORD_W      = 32;
    localparam int c_LINE_W      = c_LINE_WORDS * c_WORD_W;

    typedef logic [c_EADDR_WIDTH-1:0] eaddr_t;

    typedef enum logic [1:0] {
        FILL_IDLE    = 2'd0,
        FILL_FETCH   = 2'd1,
        FILL_INSTALL = 2'd2
    } fill_state_e;

    // Word address inside a line-aligned base; never carries into the tag bits.
    function automatic eaddr_t f_word_addr(input eaddr_t base, input logic [1:0] idx);
        return base | eaddr_t'({idx, 2'b00});
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_fill_assembler.sv
`default_nettype none
// ============================================================================
// Module  : m_fill_assembler
// Brief   : 4x32 response slot store with write pointer; presents the line in
//           address order, undoing the rotation of a wrapped fetch.
// Revision: 1.0 - initial release
// ============================================================================
module m_fill_assembler
    import m_cache_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [c_WORD_W-1:0]   i_wr_data,
    input  logic [1:0]            i_rot,
    output logic [c_LINE_W-1:0]   o_line
);

    logic [c_WORD_W-1:0] r_slot [c_LINE_WORDS];
    logic [1:0]          r_wptr;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < c_LINE_WORDS; i++) begin
                r_slot[i] <= '0;
            end
            r_wptr <= 2'd0;
        end else if (i_wr_en) begin
            r_slot[r_wptr] <= i_wr_data;
            r_wptr         <= r_wptr + 2'd1;
        end
    end

    // Slot i holds word (rot+i) mod 4, so word g lives in slot (g-rot) mod 4.
    for (genvar g = 0; g < c_LINE_WORDS; g++) begin : g_line
        logic [1:0] w_sidx;
        assign w_sidx = 2'(g) - i_rot;
        assign o_line[g*c_WORD_W +: c_WORD_W] = r_slot[w_sidx];
    end

endmodule
`default_nettype wire

// File: rtl/m_cache_fill.sv
`default_nettype none
// ============================================================================
// Module  : m_cache_fill
// Brief   : Load-miss refill controller: fetches a 4-word line over a 32-bit
//           in-order memory port and drives one cache install cycle.
//           Option macro CACHE_FILL_CRITICAL_WORD_EN: critical-word-first fetch
//           with early release of the missed load.
// Revision: 1.0 - initial release
// ============================================================================
module m_cache_fill
    import m_cache_fill_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_valid,
    input  logic [c_EADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_hit,
    output logic                  o_stall,
    output logic [c_EADDR_WIDTH-1:0] o_waddr,
    output logic                  o_bwe,
    output logic [c_LINE_W-1:0]   o_bdata,
    output logic                  o_mem_req,
    output logic [c_EADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic                  i_mem_rvalid,
    input  logic [c_WORD_W-1:0]   i_mem_rdata,
    output logic [c_WORD_W-1:0]   o_fill_word
);

    fill_state_e          r_state;
    fill_state_e          w_state_nxt;
    eaddr_t               r_base;
    logic [1:0]           r_idx;
    logic [2:0]           r_iss;
    logic [2:0]           r_rcv;

    logic                 w_miss;
    logic                 w_start;
    logic                 w_req;
    logic                 w_rsp;
    logic                 w_last;
    logic                 w_busy_stall;
    logic [2:0]           w_outst;
    logic [1:0]           w_rot;
    logic [1:0]           w_ridx;
    eaddr_t               w_start_addr;
    logic [c_LINE_W-1:0]  w_line;
    logic [c_WORD_W-1:0]  w_line_word;

    assign w_miss      = i_rd_valid & ~i_hit;
    assign w_outst     = r_iss - r_rcv;
    assign w_req       = (r_state == FILL_FETCH) && (r_iss < 3'(c_LINE_WORDS))
                         && (w_outst < 3'(MAX_OUTST));
    assign w_rsp       = (r_state == FILL_FETCH) && i_mem_rvalid && (r_rcv < 3'(c_LINE_WORDS));
    assign w_last      = w_rsp && (r_rcv == 3'(c_LINE_WORDS - 1));
    assign w_ridx      = r_iss[1:0] + w_rot;
    assign w_line_word = w_line[{r_idx, 5'd0} +: c_WORD_W];

    assign o_mem_req   = w_req;
    assign o_mem_addr  = f_word_addr(r_base, w_ridx);
    assign o_waddr     = r_base;
    assign o_bdata     = w_line;

`ifdef CACHE_FILL_CRITICAL_WORD_EN
    logic   r_early;
    logic   r_pend;
    eaddr_t r_paddr;
    logic   w_first_rsp;
    logic   w_released;
    logic   w_hold;

    assign w_first_rsp  = w_rsp && (r_rcv == 3'd0);
    assign w_released   = (r_state != FILL_IDLE) && (r_early || w_first_rsp);
    // A miss seen after the early release waits in r_pend until the fill ends.
    assign w_hold       = r_pend || (w_released && w_miss);
    assign w_start      = (r_state == FILL_IDLE) && (r_pend || w_miss);
    assign w_start_addr = r_pend ? r_paddr : i_rd_addr;
    assign w_rot        = r_idx;
    assign o_stall      = ~i_rst & ((w_busy_stall & ~w_released) | w_hold);
    assign o_fill_word  = w_first_rsp ? i_mem_rdata : w_line_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_early <= 1'b0;
            r_pend  <= 1'b0;
            r_paddr <= '0;
        end else begin
            if (r_state == FILL_INSTALL) begin
                r_early <= 1'b0;
            end else if (w_first_rsp) begin
                r_early <= 1'b1;
            end
            if (r_state == FILL_IDLE) begin
                r_pend <= 1'b0;
            end else if (w_released && w_miss && !r_pend) begin
                r_pend  <= 1'b1;
                r_paddr <= i_rd_addr;
            end
        end
    end
`else
    assign w_start      = (r_state == FILL_IDLE) && w_miss;
    assign w_start_addr = i_rd_addr;
    assign w_rot        = 2'd0;
    assign o_stall      = ~i_rst & w_busy_stall;
    assign o_fill_word  = w_line_word;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_busy_stall = 1'b0;
        o_bwe        = 1'b0;
        case (r_state)
            FILL_IDLE: begin
                if (w_start) begin
                    w_busy_stall = 1'b1;
                    w_state_nxt  = FILL_FETCH;
                end
            end
            FILL_FETCH: begin
                w_busy_stall = 1'b1;
                if (w_last) begin
                    w_state_nxt = FILL_INSTALL;
                end
            end
            FILL_INSTALL: begin
                w_busy_stall = 1'b1;
                o_bwe        = 1'b1;
                w_state_nxt  = FILL_IDLE;
            end
            default: begin
                w_state_nxt = FILL_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FILL_IDLE;
            r_base  <= '0;
            r_idx   <= 2'd0;
            r_iss   <= 3'd0;
            r_rcv   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_base <= w_start_addr & ~eaddr_t'(4'hF);
                r_idx  <= w_start_addr[3:2];
                r_iss  <= 3'd0;
                r_rcv  <= 3'd0;
            end else begin
                if (w_req && i_mem_ack) begin
                    r_iss <= r_iss + 3'd1;
                end
                if (w_rsp) begin
                    r_rcv <= r_rcv + 3'd1;
                end
            end
        end
    end

    m_fill_assembler u_asm (
        .clk       (i_clk),
        .rst       (i_rst),
        .i_clear   (w_start),
        .i_wr_en   (w_rsp),
        .i_wr_data (i_mem_rdata),
        .i_rot     (w_rot),
        .o_line    (w_line)
    );

endmodule
`default_nettype wire

// File: tb/tb_m_cache_fill.sv
`default_nettype none
// ============================================================================
// Module  : tb_m_cache_fill
// Brief   : Directed self-checking bench for m_cache_fill with an in-order
//           memory responder (configurable ack pattern and response latency).
// Revision: 1.0 - initial release
// ============================================================================
module tb_m_cache_fill;

    localparam int TB_OUTST = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_valid = 1'b0;
    logic [31:0]   rd_addr = '0;
    logic          hit = 1'b0;
    logic          stall;
    logic [31:0]   waddr;
    logic          bwe;
    logic [127:0]  bdata;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack = 1'b1;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   fill_word;

    always #5 clk = ~clk;

    m_cache_fill #(.MAX_OUTST(TB_OUTST)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rd_valid   (rd_valid),
        .i_rd_addr    (rd_addr),
        .i_hit        (hit),
        .o_stall      (stall),
        .o_waddr      (waddr),
        .o_bwe        (bwe),
        .o_bdata      (bdata),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_fill_word  (fill_word)
    );

    int nchk = 0;
    int nerr = 0;

    // Memory responder: data word = dbase + word index within the line.
    logic [31:0] q_data[$];
    int          q_due[$];
    logic [31:0] req_log[$];
    int          cyc = 0, lat = 1, n_out = 0, max_out = 0, n_resp = 0, nbwe = 0;
    logic        ack3 = 1'b0;
    logic [31:0] dbase = 32'hA0;

    always @(negedge clk) begin
        cyc++;
        if (bwe === 1'b1) nbwe++;
        if (rst) begin
            q_data.delete();
            q_due.delete();
            mem_rvalid = 1'b0;
            n_out = 0;
        end else begin
            mem_rvalid = 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q_data.pop_front();
                void'(q_due.pop_front());
                n_out--;
                n_resp++;
            end
            mem_ack = ack3 ? (cyc % 3 == 0) : 1'b1;
            if (mem_req && mem_ack) begin
                req_log.push_back(mem_addr);
                q_data.push_back(dbase + 32'(mem_addr[3:2]));
                q_due.push_back(cyc + lat);
                n_out++;
                if (n_out > max_out) max_out = n_out;
            end
        end
    end

    task automatic wait_bwe(input int budget, output int ncyc);
        ncyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (bwe === 1'b1) begin
                ncyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            nchk++;
            if ({stall, bwe, mem_req} !== 3'b000) begin
                nerr++; $display("FAIL reset_ctrl cyc%0d: stall/bwe/req=%b expected 000", i, {stall, bwe, mem_req});
            end
        end
        nchk++; if (waddr !== 32'h0) begin nerr++; $display("FAIL reset_waddr: got %h expected 0", waddr); end
        nchk++; if (bdata !== 128'h0) begin nerr++; $display("FAIL reset_bdata: got %h expected 0", bdata); end
        nchk++; if (mem_addr !== 32'h0) begin nerr++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        nchk++; if (fill_word !== 32'h0) begin nerr++; $display("FAIL reset_fill_word: got %h expected 0", fill_word); end
        @(negedge clk);
        rst = 1'b0; rd_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_miss;
        int n, b0;
        logic [31:0] exp_a [4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        req_log.delete(); dbase = 32'hA0; b0 = nbwe;
        @(negedge clk); rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h0000_1234; #1;
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL miss_stall_comb: got %b expected 1", stall); end
        wait_bwe(30, n);
        nchk++; if (n !== 6) begin nerr++; $display("FAIL miss_latency: got %0d expected 6", n); end
        nchk++; if (waddr !== 32'h1230) begin nerr++; $display("FAIL miss_waddr: got %h expected 1230", waddr); end
        nchk++; if (bdata !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin nerr++; $display("FAIL miss_bdata: got %h", bdata); end
        nchk++; if (fill_word !== 32'hA1) begin nerr++; $display("FAIL miss_fill_word: got %h expected A1", fill_word); end
`ifndef CACHE_FILL_CRITICAL_WORD_EN
        nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL miss_stall_install: got %b expected 1", stall); end
`endif
        @(negedge clk); #1;
        nchk++; if ({stall, bwe} !== 2'b00) begin nerr++; $display("FAIL miss_release: stall/bwe=%b expected 00", {stall, bwe}); end
        repeat (4) @(negedge clk);
        nchk++; if (req_log.size() !== 4) begin nerr++; $display("FAIL miss_req_count: got %0d expected 4", req_log.size()); end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            nchk++;
            if (req_log[i] !== exp_a[i]) begin nerr++; $display("FAIL miss_req_addr%0d: got %h expected %h", i, req_log[i], exp_a[i]); end
        end
        nchk++; if (nbwe - b0 !== 1) begin nerr++; $display("FAIL miss_bwe_count: got %0d expected 1", nbwe - b0); end
    endtask

    task automatic test_hit_and_busy_miss;
        int n, b0;
        req_log.delete(); dbase = 32'hB0; b0 = nbwe;
        @(negedge clk); rd_valid = 1'b1; hit = 1'b1; rd_addr = 32'h5554; #1;
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL hit_stall: got %b expected 0", stall); end
        @(negedge clk); rd_valid = 1'b0;
        repeat (3) @(negedge clk);
        nchk++; if (req_log.size() !== 0) begin nerr++; $display("FAIL hit_no_req: got %0d requests expected 0", req_log.size()); end
        @(negedge clk); rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h2008;
        @(negedge clk); rd_addr = 32'h3000;
        wait_bwe(30, n);
        nchk++; if (n !== 5) begin nerr++; $display("FAIL busy_latency: got %0d expected 5", n); end
        nchk++; if (waddr !== 32'h2000) begin nerr++; $display("FAIL busy_waddr: got %h expected 2000", waddr); end
        nchk++; if (fill_word !== 32'hB2) begin nerr++; $display("FAIL busy_fill_word: got %h expected B2", fill_word); end
        repeat (10) @(negedge clk); #1;
        nchk++; if (req_log.size() !== 4) begin nerr++; $display("FAIL busy_req_count: got %0d expected 4", req_log.size()); end
        nchk++; if (nbwe - b0 !== 1) begin nerr++; $display("FAIL busy_bwe_count: got %0d expected 1", nbwe - b0); end
        nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL busy_idle_stall: got %b expected 0", stall); end
    endtask

    task automatic test_backpressure;
        int n;
        req_log.delete(); dbase = 32'hA0; ack3 = 1'b1; lat = 8; max_out = 0;
        @(negedge clk); rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h1234;
        wait_bwe(150, n);
        nchk++; if (n < 0) begin nerr++; $display("FAIL bp_timeout: got no o_bwe expected one within 150 cycles"); end
        nchk++; if (bdata !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin nerr++; $display("FAIL bp_bdata: got %h", bdata); end
        nchk++; if (waddr !== 32'h1230) begin nerr++; $display("FAIL bp_waddr: got %h expected 1230", waddr); end
        nchk++; if (max_out !== TB_OUTST) begin nerr++; $display("FAIL bp_max_outstanding: got %0d expected %0d", max_out, TB_OUTST); end
        nchk++; if (req_log.size() !== 4) begin nerr++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
        ack3 = 1'b0; lat = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int n, b0, r0;
        req_log.delete(); dbase = 32'hC0; b0 = nbwe; r0 = n_resp;
        @(negedge clk); rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h1234;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            rd_valid = 1'b0;
            if (n_resp - r0 >= 2) break;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk); #1;
        nchk++; if (nbwe - b0 !== 0) begin nerr++; $display("FAIL abort_no_bwe: got %0d installs expected 0", nbwe - b0); end
        nchk++; if ({stall, mem_req} !== 2'b00) begin nerr++; $display("FAIL abort_idle: stall/req=%b expected 00", {stall, mem_req}); end
        req_log.delete(); dbase = 32'hD0;
        @(negedge clk); rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h40;
        wait_bwe(30, n);
        nchk++; if (n !== 6) begin nerr++; $display("FAIL clean_latency: got %0d expected 6", n); end
        nchk++; if (waddr !== 32'h40) begin nerr++; $display("FAIL clean_waddr: got %h expected 40", waddr); end
        nchk++; if (bdata !== {32'hD3, 32'hD2, 32'hD1, 32'hD0}) begin nerr++; $display("FAIL clean_bdata: got %h", bdata); end
        nchk++; if (fill_word !== 32'hD0) begin nerr++; $display("FAIL clean_fill_word: got %h expected D0", fill_word); end
        repeat (3) @(negedge clk);
    endtask

`ifdef CACHE_FILL_CRITICAL_WORD_EN
    task automatic test_critical;
        int n;
        logic seen;
        logic [31:0] exp_a [4] = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
        req_log.delete(); dbase = 32'hA0; seen = 1'b0;
        @(negedge clk); rd_valid = 1'b1; hit = 1'b0; rd_addr = 32'h1238;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            rd_valid = 1'b0;
            if (mem_rvalid) begin
                seen = 1'b1;
                nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL crit_early_stall: got %b expected 0", stall); end
                nchk++; if (fill_word !== 32'hA2) begin nerr++; $display("FAIL crit_early_word: got %h expected A2", fill_word); end
            end
        end
        wait_bwe(30, n);
        nchk++; if (bdata !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin nerr++; $display("FAIL crit_bdata: got %h", bdata); end
        nchk++; if (waddr !== 32'h1230) begin nerr++; $display("FAIL crit_waddr: got %h expected 1230", waddr); end
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (i >= req_log.size() || req_log[i] !== exp_a[i]) begin
                nerr++; $display("FAIL crit_req_addr%0d: got %h expected %h", i, (i < req_log.size()) ? req_log[i] : 32'hX, exp_a[i]);
            end
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_miss();
        test_hit_and_busy_miss();
        test_backpressure();
        test_reset_abort();
`ifdef CACHE_FILL_CRITICAL_WORD_EN
        test_critical();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
